isram_ctrl: RTL and testbench

ISRAM_CTRL -- requirements
Module: isram_ctrl

---
 rtl/isram_ctrl_if.sv | 37 +++
 rtl/isram_ctrl.sv | 126 ++++++++++++
 tb/tb_isram_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/isram_ctrl_if.sv
// Request and status-array bus of the instruction-SRAM status controller.
// The controller takes the slave modport; requesters/array model take the master side.
`ifndef I_INDEX_WIDTH
`define I_INDEX_WIDTH 3
`endif

interface isram_ctrl_if #(
    parameter int unsigned IW = `I_INDEX_WIDTH
);
    logic          flush_req;
    logic          flush_busy;
    logic          fill_req;
    logic [IW-1:0] fill_index;
    logic          fill_sec;
    logic          fill_ack;
    logic [1:0]    fill_way;
    logic          lk_req;
    logic [IW-1:0] lk_index;
    logic          lk_gnt;
    logic [IW-1:0] sram_index;
    logic [1:0]    sram_way;
    logic [1:0]    sram_din;
    logic          sram_we;
    logic          sram_en;

    modport master (
        output flush_req, fill_req, fill_index, fill_sec, lk_req, lk_index,
        input  flush_busy, fill_ack, fill_way, lk_gnt,
        input  sram_index, sram_way, sram_din, sram_we, sram_en
    );

    modport slave (
        input  flush_req, fill_req, fill_index, fill_sec, lk_req, lk_index,
        output flush_busy, fill_ack, fill_way, lk_gnt,
        output sram_index, sram_way, sram_din, sram_we, sram_en
    );
endinterface

// File: rtl/isram_ctrl.sv
// Status-array port arbiter for a 4-way I-SRAM: invalidation sweep, partitioned
// round-robin fills and lookups, in that priority order.
`ifndef I_INDEX_WIDTH
`define I_INDEX_WIDTH 3
`endif

module isram_ctrl #(
    parameter int unsigned IW  = `I_INDEX_WIDTH,
    parameter int unsigned NUM = (1 << IW)
) (
    input logic         i_clk,
    input logic         i_rst_n,
    isram_ctrl_if.slave io_bus
);
    localparam int unsigned   CW      = IW + 2;
    localparam logic [CW-1:0] CntLast = CW'(4 * NUM - 1);

    typedef enum logic [1:0] {StIdle, StFlush, StFill} state_e;

    state_e        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_victim, w_victim_nxt;
    logic [IW-1:0] r_fill_index, w_fill_index_nxt;
    logic          r_fill_sec, w_fill_sec_nxt;

    logic          w_flush_busy;
    logic          w_fill_ack;
    logic [1:0]    w_fill_way;
    logic          w_lk_gnt;
    logic [IW-1:0] w_sram_index;
    logic [1:0]    w_sram_way;
    logic [1:0]    w_sram_din;
    logic          w_sram_we;
    logic          w_sram_en;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= StFlush;
            r_cnt        <= '0;
            r_victim     <= '0;
            r_fill_index <= '0;
            r_fill_sec   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_victim     <= w_victim_nxt;
            r_fill_index <= w_fill_index_nxt;
            r_fill_sec   <= w_fill_sec_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_victim_nxt     = r_victim;
        w_fill_index_nxt = r_fill_index;
        w_fill_sec_nxt   = r_fill_sec;
        w_flush_busy     = 1'b0;
        w_fill_ack       = 1'b0;
        w_fill_way       = 2'b00;
        w_lk_gnt         = 1'b0;
        w_sram_index     = '0;
        w_sram_way       = 2'b00;
        w_sram_din       = 2'b00;
        w_sram_we        = 1'b0;
        w_sram_en        = 1'b0;

        // Outputs are held quiet while reset is asserted, whatever the state register holds.
        if (i_rst_n) begin
            case (r_state)
                StIdle: begin
                    if (io_bus.flush_req) begin
                        w_state_nxt = StFlush;
                        w_cnt_nxt   = '0;
                    end else if (io_bus.fill_req) begin
                        w_state_nxt      = StFill;
                        w_fill_index_nxt = io_bus.fill_index;
                        w_fill_sec_nxt   = io_bus.fill_sec;
                    end else if (io_bus.lk_req) begin
                        w_lk_gnt     = 1'b1;
                        w_sram_en    = 1'b1;
                        w_sram_index = io_bus.lk_index;
                    end
                end
                StFill: begin
                    w_sram_en                = 1'b1;
                    w_sram_we                = 1'b1;
                    w_sram_index             = r_fill_index;
                    w_sram_way               = {r_fill_sec, r_victim[r_fill_sec]};
                    w_sram_din               = 2'b01;
                    w_fill_ack               = 1'b1;
                    w_fill_way               = {r_fill_sec, r_victim[r_fill_sec]};
                    w_victim_nxt[r_fill_sec] = ~r_victim[r_fill_sec];
                    w_state_nxt              = StIdle;
                end
                StFlush: begin
                    w_flush_busy = 1'b1;
                    w_sram_en    = 1'b1;
                    w_sram_we    = 1'b1;
                    w_sram_index = r_cnt[CW-1:2];
                    w_sram_way   = r_cnt[1:0];
                    if (r_cnt == CntLast) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = StIdle;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = StFlush;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign io_bus.flush_busy = w_flush_busy;
    assign io_bus.fill_ack   = w_fill_ack;
    assign io_bus.fill_way   = w_fill_way;
    assign io_bus.lk_gnt     = w_lk_gnt;
    assign io_bus.sram_index = w_sram_index;
    assign io_bus.sram_way   = w_sram_way;
    assign io_bus.sram_din   = w_sram_din;
    assign io_bus.sram_we    = w_sram_we;
    assign io_bus.sram_en    = w_sram_en;
endmodule

// File: tb/tb_isram_ctrl.sv
// Directed bench for isram_ctrl: every array write is matched in order against a
// queue of expected {index, way, din} entries pushed when the stimulus is applied.
module tb_isram_ctrl;
    localparam int unsigned IW = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [6:0] sb[$];

    isram_ctrl_if #(.IW(IW)) bus ();

    isram_ctrl #(.IW(IW), .NUM(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [2:0] idx, input logic [1:0] way, input logic [1:0] din);
        sb.push_back({idx, way, din});
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 32; i++) sb_push(3'(i >> 2), 2'(i & 3), 2'b00);
    endtask

    // Settle combinational outputs, then retire any array write against the scoreboard.
    task automatic sample();
        logic [6:0] e;
        #1;
        if (bus.sram_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("sram_write", {bus.sram_index, bus.sram_way, bus.sram_din}, e);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, bus.sram_en, 0);
        chk({tag, "_we"}, bus.sram_we, 0);
        chk({tag, "_index"}, bus.sram_index, 0);
        chk({tag, "_way"}, bus.sram_way, 0);
        chk({tag, "_din"}, bus.sram_din, 0);
        chk({tag, "_busy"}, bus.flush_busy, 0);
        chk({tag, "_gnt"}, bus.lk_gnt, 0);
        chk({tag, "_ack"}, bus.fill_ack, 0);
        chk({tag, "_fill_way"}, bus.fill_way, 0);
    endtask

    // Called with the first busy cycle already sampled; returns busy length and any grant seen.
    task automatic run_sweep(input int flush_at, input int fill_at, output int n, output int g);
        n = (bus.flush_busy === 1'b1) ? 1 : 0;
        g = (bus.lk_gnt === 1'b1) ? 1 : 0;
        for (int c = 1; c < 60; c++) begin
            edge_();
            bus.flush_req = (c == flush_at);
            if (c == fill_at) begin
                bus.fill_req   = 1'b1;
                bus.fill_index = 3'd7;
                bus.fill_sec   = 1'b1;
                sb_push(3'd7, 2'd3, 2'b01);
            end
            sample();
            if (bus.flush_busy !== 1'b1) break;
            n++;
            if (bus.lk_gnt === 1'b1) g++;
        end
    endtask

    task automatic do_fill(input logic [2:0] idx, input logic sec, input logic lk,
                           input logic [2:0] lk_idx, input logic [1:0] exp_way);
        edge_();
        bus.fill_req   = 1'b1;
        bus.fill_index = idx;
        bus.fill_sec   = sec;
        bus.lk_req     = lk;
        bus.lk_index   = lk_idx;
        sb_push(idx, exp_way, 2'b01);
        sample();
        chk("req_gnt", bus.lk_gnt, 0);
        chk("req_en", bus.sram_en, 0);
        edge_();
        sample();
        chk("fill_ack", bus.fill_ack, 1);
        chk("fill_way", bus.fill_way, exp_way);
        chk("fill_gnt", bus.lk_gnt, 0);
        edge_();
        bus.fill_req = 1'b0;
        sample();
        chk("post_ack", bus.fill_ack, 0);
        if (lk) begin
            chk("post_lk_gnt", bus.lk_gnt, 1);
            chk("post_lk_index", bus.sram_index, lk_idx);
            chk("post_lk_we", bus.sram_we, 0);
        end
    endtask

    initial begin
        int n;
        int g;
        rst_n          = 1'b0;
        bus.flush_req  = 1'b0;
        bus.fill_req   = 1'b0;
        bus.fill_index = '0;
        bus.fill_sec   = 1'b0;
        bus.lk_req     = 1'b1;
        bus.lk_index   = 3'd5;

        repeat (3) edge_();
        sample();
        chk_zero("rst");

        // Post-reset sweep with a lookup held the whole time.
        edge_();
        rst_n = 1'b1;
        push_sweep();
        sample();
        chk("busy_first", bus.flush_busy, 1);
        run_sweep(0, 0, n, g);
        chk("sweep_len", n, 32);
        chk("sweep_gnt", g, 0);
        chk("idle_busy", bus.flush_busy, 0);
        chk("idle_lk_gnt", bus.lk_gnt, 1);
        chk("idle_lk_index", bus.sram_index, 5);

        edge_();
        bus.lk_index = 3'd2;
        sample();
        chk("lk_gnt", bus.lk_gnt, 1);
        chk("lk_en", bus.sram_en, 1);
        chk("lk_index", bus.sram_index, 2);
        chk("lk_we", bus.sram_we, 0);
        edge_();
        bus.lk_req = 1'b0;
        sample();
        chk("nolk_en", bus.sram_en, 0);
        chk("nolk_index", bus.sram_index, 0);
        chk("nolk_gnt", bus.lk_gnt, 0);

        do_fill(3'd5, 1'b0, 1'b0, 3'd0, 2'd0);
        do_fill(3'd5, 1'b0, 1'b0, 3'd0, 2'd1);
        do_fill(3'd4, 1'b1, 1'b0, 3'd0, 2'd2);
        do_fill(3'd6, 1'b1, 1'b0, 3'd0, 2'd3);
        do_fill(3'd1, 1'b1, 1'b0, 3'd0, 2'd2);
        do_fill(3'd2, 1'b0, 1'b0, 3'd0, 2'd0);
        do_fill(3'd3, 1'b0, 1'b1, 3'd6, 2'd1);

        // Sweep with a re-request mid-sweep and a fill held pending.
        edge_();
        bus.flush_req = 1'b1;
        bus.lk_req    = 1'b1;
        bus.lk_index  = 3'd4;
        push_sweep();
        sample();
        chk("flreq_gnt", bus.lk_gnt, 0);
        chk("flreq_en", bus.sram_en, 0);
        edge_();
        bus.flush_req = 1'b0;
        sample();
        chk("busy_start", bus.flush_busy, 1);
        run_sweep(10, 5, n, g);
        chk("resweep_len", n, 32);
        chk("resweep_gnt", g, 0);
        chk("pend_en", bus.sram_en, 0);
        chk("pend_gnt", bus.lk_gnt, 0);
        edge_();
        sample();
        chk("pend_ack", bus.fill_ack, 1);
        chk("pend_way", bus.fill_way, 3);
        chk("pend_gnt_fill", bus.lk_gnt, 0);
        edge_();
        bus.fill_req = 1'b0;
        bus.lk_req   = 1'b0;
        sample();
        chk("pend_post_ack", bus.fill_ack, 0);

        // Leave the low victim at 1 so the reset below must clear it.
        do_fill(3'd0, 1'b0, 1'b0, 3'd0, 2'd0);

        edge_();
        bus.flush_req = 1'b1;
        push_sweep();
        sample();
        edge_();
        bus.flush_req = 1'b0;
        sample();
        repeat (19) begin
            edge_();
            sample();
        end
        edge_();
        rst_n      = 1'b0;
        bus.lk_req = 1'b1;
        sample();
        chk_zero("midrst");
        sb.delete();
        edge_();
        rst_n      = 1'b1;
        bus.lk_req = 1'b0;
        push_sweep();
        sample();
        chk("rst_busy", bus.flush_busy, 1);
        run_sweep(0, 0, n, g);
        chk("rst_sweep_len", n, 32);
        do_fill(3'd1, 1'b0, 1'b0, 3'd0, 2'd0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
